// File: rtl/imu_spi_scheduler.sv
// Sequences the byte-level SPI engine: one config write per sensor after reset, then
// gyro+accel burst reads on each sample tick, forwarding data bytes as a byte stream.
module imu_spi_scheduler #(
    parameter int         SAMPLE_DIV = 100000,
    parameter logic [7:0] G_CFG_ADDR = 8'h20,
    parameter logic [7:0] G_CFG_DATA = 8'h0F,
    parameter logic [7:0] A_CFG_ADDR = 8'h2D,
    parameter logic [7:0] A_CFG_DATA = 8'h08,
    parameter logic [7:0] G_RD_CMD   = 8'hE8,
    parameter logic [7:0] A_RD_CMD   = 8'hF2,
    parameter int         G_NBYTES   = 6,
    parameter int         A_NBYTES   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       spi_start,
    output logic [7:0] spi_tx_byte,
    output logic       spi_dev_sel,
    output logic       spi_cs_hold,
    input  logic       spi_done,
    input  logic [7:0] spi_rx_byte,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       init_done,
    output logic       frame_busy,
    output logic [7:0] overrun_count,
    output logic [2:0] dbg_state
);

    localparam int         CW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [3:0] G_LAST = 4'(G_NBYTES);
    localparam logic [3:0] A_LAST = 4'(A_NBYTES);

    typedef enum logic [2:0] {
        CFG_G     = 3'd0,
        CFG_A     = 3'd1,
        WAIT_TICK = 3'd2,
        RD_G      = 3'd3,
        RD_A      = 3'd4
    } state_t;

    // Handshake with the byte engine: spi_start pulses for one cycle with tx/dev/hold valid
    // and held until spi_done; spi_done only counts from the cycle after spi_start (wait_q).
    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          boot_q, boot_d;
    logic          wait_q, wait_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          start_q, start_d;
    logic [7:0]    tx_q, tx_d;
    logic          dev_q, dev_d;
    logic          hold_q, hold_d;
    logic          ov_q, ov_d;
    logic [7:0]    ob_q, ob_d;
    logic          ol_q, ol_d;
    logic          init_q, init_d;
    logic          fb_q, fb_d;
    logic [7:0]    ovr_q, ovr_d;

    logic          tick;
    logic          done_acc;
    logic          issue;
    state_t        issue_state;
    logic [3:0]    issue_idx;
    logic [9:0]    issue_word;

    // Returns {dev, hold, byte} for byte slot idx of a sequence.
    function automatic logic [9:0] slot_word(input state_t st, input logic [3:0] idx);
        logic [9:0] w;
        w = 10'd0;
        case (st)
            CFG_G:   w = (idx == 4'd0) ? {1'b0, 1'b1, G_CFG_ADDR} : {1'b0, 1'b0, G_CFG_DATA};
            CFG_A:   w = (idx == 4'd0) ? {1'b1, 1'b1, A_CFG_ADDR} : {1'b1, 1'b0, A_CFG_DATA};
            RD_G:    w = (idx == 4'd0) ? {1'b0, 1'b1, G_RD_CMD} : {1'b0, idx != G_LAST, 8'h00};
            RD_A:    w = (idx == 4'd0) ? {1'b1, 1'b1, A_RD_CMD} : {1'b1, idx != A_LAST, 8'h00};
            default: w = 10'd0;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] last_idx(input state_t st);
        logic [3:0] l;
        case (st)
            RD_G:    l = G_LAST;
            RD_A:    l = A_LAST;
            default: l = 4'd1;
        endcase
        return l;
    endfunction

    assign tick     = (tick_cnt_q == CW'(SAMPLE_DIV - 1));
    assign done_acc = wait_q & spi_done;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        boot_d      = boot_q;
        wait_d      = wait_q | start_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
        start_d     = 1'b0;
        tx_d        = tx_q;
        dev_d       = dev_q;
        hold_d      = hold_q;
        ov_d        = 1'b0;
        ob_d        = ob_q;
        ol_d        = 1'b0;
        init_d      = init_q;
        fb_d        = fb_q;
        ovr_d       = ovr_q;
        issue       = 1'b0;
        issue_state = state_q;
        issue_idx   = idx_q;
        issue_word  = 10'd0;

        // Ticks are never queued: outside WAIT_TICK they are only counted.
        if (tick && state_q != WAIT_TICK && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            CFG_G, CFG_A, RD_G, RD_A: begin
                if (boot_q) begin
                    boot_d = 1'b0;
                    issue  = 1'b1;
                end else if (done_acc) begin
                    wait_d = 1'b0;
                    if ((state_q == RD_G || state_q == RD_A) && idx_q != 4'd0) begin
                        ov_d = 1'b1;
                        ob_d = spi_rx_byte;
                        ol_d = (state_q == RD_A) && (idx_q == A_LAST);
                    end
                    if (idx_q == last_idx(state_q)) begin
                        idx_d = 4'd0;
                        case (state_q)
                            CFG_G: begin
                                state_d     = CFG_A;
                                issue       = 1'b1;
                                issue_state = CFG_A;
                                issue_idx   = 4'd0;
                            end
                            CFG_A: begin
                                state_d = WAIT_TICK;
                                init_d  = 1'b1;
                            end
                            RD_G: begin
                                state_d     = RD_A;
                                issue       = 1'b1;
                                issue_state = RD_A;
                                issue_idx   = 4'd0;
                            end
                            default: begin
                                state_d = WAIT_TICK;
                                fb_d    = 1'b0;
                            end
                        endcase
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        issue     = 1'b1;
                        issue_idx = idx_q + 4'd1;
                    end
                end
            end
            WAIT_TICK: begin
                if (tick && enable) begin
                    state_d     = RD_G;
                    idx_d       = 4'd0;
                    fb_d        = 1'b1;
                    issue       = 1'b1;
                    issue_state = RD_G;
                    issue_idx   = 4'd0;
                end
            end
            default: state_d = CFG_G;
        endcase

        if (issue) begin
            issue_word = slot_word(issue_state, issue_idx);
            start_d    = 1'b1;
            dev_d      = issue_word[9];
            hold_d     = issue_word[8];
            tx_d       = issue_word[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CFG_G;
            idx_q      <= 4'd0;
            boot_q     <= 1'b1;
            wait_q     <= 1'b0;
            tick_cnt_q <= '0;
            start_q    <= 1'b0;
            tx_q       <= 8'd0;
            dev_q      <= 1'b0;
            hold_q     <= 1'b0;
            ov_q       <= 1'b0;
            ob_q       <= 8'd0;
            ol_q       <= 1'b0;
            init_q     <= 1'b0;
            fb_q       <= 1'b0;
            ovr_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            boot_q     <= boot_d;
            wait_q     <= wait_d;
            tick_cnt_q <= tick_cnt_d;
            start_q    <= start_d;
            tx_q       <= tx_d;
            dev_q      <= dev_d;
            hold_q     <= hold_d;
            ov_q       <= ov_d;
            ob_q       <= ob_d;
            ol_q       <= ol_d;
            init_q     <= init_d;
            fb_q       <= fb_d;
            ovr_q      <= ovr_d;
        end
    end

    assign spi_start     = start_q;
    assign spi_tx_byte   = tx_q;
    assign spi_dev_sel   = dev_q;
    assign spi_cs_hold   = hold_q;
    assign out_valid     = ov_q;
    assign out_byte      = ob_q;
    assign out_last      = ol_q;
    assign init_done     = init_q;
    assign frame_busy    = fb_q;
    assign overrun_count = ovr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_imu_spi_scheduler.sv
// Randomized bench for imu_spi_scheduler: an SPI byte responder with random latency and
// spurious done pulses, checked every cycle against a transaction-level sensor model.
module tb_imu_spi_scheduler;

    localparam int DIV = 40;
    localparam int G_N = 6;
    localparam int A_N = 6;

    logic       clk = 1'b0;
    logic       reset, enable, spi_done;
    logic [7:0] spi_rx_byte;
    logic       spi_start, spi_dev_sel, spi_cs_hold;
    logic [7:0] spi_tx_byte;
    logic       out_valid, out_last, init_done, frame_busy;
    logic [7:0] out_byte, overrun_count;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    imu_spi_scheduler #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_dev_sel(spi_dev_sel),
        .spi_cs_hold(spi_cs_hold), .spi_done(spi_done), .spi_rx_byte(spi_rx_byte),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
        .init_done(init_done), .frame_busy(frame_busy), .overrun_count(overrun_count),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- responder / driver ----------------
    int lat_min = 1, lat_max = 1;
    bit spur_en = 0;
    bit resp_out = 0;
    int resp_due = 0;

    task automatic respond();
        spi_done = 1'b0;
        if (reset) begin
            resp_out = 0;
        end else begin
            if (resp_out && cyc == resp_due) begin
                spi_done    = 1'b1;
                spi_rx_byte = 8'($urandom);
                resp_out    = 0;
            end else if (spur_en && !resp_out && $urandom_range(0, 3) == 0) begin
                spi_done    = 1'b1;
                spi_rx_byte = 8'($urandom);
            end
            if (spi_start) begin
                resp_out = 1;
                resp_due = cyc + int'($urandom_range(lat_min, lat_max));
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            respond();
        end
    endtask

    // ---------------- reference model ----------------
    // slot = {end_frame, end_cfg, is_last, is_data, hold, dev, tx}
    logic [13:0] exp_q[$];
    logic [13:0] cur;
    bit          m_busy = 1, has_out = 0;
    int          out_start = 0, c0 = 0, e_ovr = 0, rel;
    logic        e_start = 0, e_ov = 0, e_ol = 0, e_fb = 0, e_init = 0;
    logic [7:0]  e_ob = 8'd0;

    function automatic logic [13:0] mk(input logic dev, input logic hold, input logic [7:0] tx,
                                       input logic is_data, input logic is_last,
                                       input logic end_cfg, input logic end_frame);
        return {end_frame, end_cfg, is_last, is_data, hold, dev, tx};
    endfunction

    task automatic load_cfg();
        exp_q.push_back(mk(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic load_frame();
        exp_q.push_back(mk(1'b0, 1'b1, 8'hE8, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= G_N; k++)
            exp_q.push_back(mk(1'b0, k != G_N, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b1, 8'hF2, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= A_N; k++)
            exp_q.push_back(mk(1'b1, k != A_N, 8'h00, 1'b1, k == A_N, 1'b0, k == A_N));
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check_eq("spi_start", spi_start, e_start);
            if (e_start) begin
                if (exp_q.size() == 0) begin
                    check_eq("slot_avail", 0, 1);
                end else begin
                    cur       = exp_q.pop_front();
                    has_out   = 1;
                    out_start = cyc;
                    if (spi_start) begin
                        check_eq("spi_dev_sel", spi_dev_sel, cur[8]);
                        check_eq("spi_tx_byte", spi_tx_byte, cur[7:0]);
                        check_eq("spi_cs_hold", spi_cs_hold, cur[9]);
                    end
                end
            end
            check_eq("out_valid", out_valid, e_ov);
            check_eq("out_last", out_last, e_ov & e_ol);
            if (e_ov && out_valid) check_eq("out_byte", out_byte, e_ob);
            check_eq("frame_busy", frame_busy, e_fb);
            check_eq("init_done", init_done, e_init);
            check_eq("overrun_count", overrun_count, e_ovr);
        end

        e_start = 0;
        e_ov    = 0;
        e_ol    = 0;
        if (reset) begin
            exp_q.delete();
            load_cfg();
            m_busy  = 1;
            has_out = 0;
            e_fb    = 0;
            e_init  = 0;
            e_ovr   = 0;
            c0      = cyc + 1;
        end else begin
            rel = cyc - c0;
            if (cyc == c0) e_start = 1;
            if (rel % DIV == DIV - 1) begin
                if (m_busy) begin
                    if (e_ovr < 255) e_ovr++;
                end else if (enable) begin
                    load_frame();
                    m_busy  = 1;
                    e_fb    = 1;
                    e_start = 1;
                end
            end
            if (has_out && cyc > out_start && spi_done) begin
                has_out = 0;
                if (cur[10]) begin
                    e_ov = 1;
                    e_ob = spi_rx_byte;
                    e_ol = cur[11];
                end
                if (cur[12]) begin
                    e_init = 1;
                    m_busy = 0;
                end else if (cur[13]) begin
                    e_fb   = 0;
                    m_busy = 0;
                end else begin
                    e_start = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        reset       = 1'b1;
        enable      = 1'b1;
        spi_done    = 1'b0;
        spi_rx_byte = 8'd0;
        run(4);
        reset = 1'b0;

        // fast engine: frames fit between ticks
        run(400);

        // slow/random engine: frames span ticks, overruns
        lat_max = 6;
        run(1500);

        // drop enable while the gyro burst is in flight
        for (k = 0; k < 400 && !(frame_busy && !spi_dev_sel); k++) run(1);
        check_eq("wait_rd_g", k < 400, 1);
        enable = 1'b0;
        run(300);
        enable = 1'b1;
        run(300);

        repeat (20) begin
            enable = 1'($urandom_range(0, 1));
            run(int'($urandom_range(10, 80)));
        end
        enable = 1'b1;

        // reset in the middle of the accel burst
        for (k = 0; k < 400 && !(frame_busy && spi_dev_sel); k++) run(1);
        check_eq("wait_rd_a", k < 400, 1);
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(400);

        // spurious done pulses
        spur_en = 1;
        run(2000);
        spur_en = 0;

        // long frames to drive the overrun counter into saturation
        lat_min = 6;
        lat_max = 6;
        run(18000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
